prco_exu: RTL and testbench
===========================

# prco_exu

Execute-side block of the PRCO 16-bit core: a registered instruction decoder, a single-cycle ALU with compare flags and branch resolution, and a small output-port latch (UART1 byte, GPIO1 byte). It sits between local-memory fetch and the register file. The core supplies stage-enable pulses and register operands. The block returns the decoded fields, the result, the stage-done pulses and the branch request.

## Interface
- No parameters; widths are fixed in `prco_pkg`.
- i_clk  in  1  clock; reset i_reset, asynchronous, active-high; clock i_clk.
- i_reset  in  1  async active-high reset.
- i_en  in  1  decoder enable; when low, i_ce_dec is ignored.
- i_ce_dec  in  1  instruction-valid pulse.
- i_instr  in  16  instruction word.
- q_ce_dec  out  1  decode done; register read required.
- q_fetch  out  1  decode done; no further stages (NOP/undefined).
- q_op  out  6  opcode, {1'b0, instr[15:11]}.
- q_seld  out  3  instr[10:8]: Rd, or condition code for Jcc.
- q_sela  out  3  instr[7:5]: Ra.
- q_selb  out  3  instr[4:2]: Rb.
- q_third_sel  out  1  3-register form (Rd = Ra op Rb); equals instr[0] for reg-reg ALU ops, 0 otherwise.
- q_imm8  out  16  zero-extended instr[7:0].
- q_simm5  out  5  instr[4:0].
- q_reg_we  out  1  instruction writes Rd.
- q_req_ram  out  1  LW/SW.
- q_req_ram_we  out  1  SW.
- q_new_uart1_data  out  1  UART op.
- i_ce_alu  in  1  operands-valid pulse.
- i_dec_req_ram  in  1  route completion to RAM (normally q_req_ram).
- i_data  in  16  Ra value.
- i_datb  in  16  Rd value.
- q_ce_ram  out  1  ALU done, memory access next.
- q_ce_reg  out  1  ALU done, write-back next.
- q_result  out  16  ALU result / address / branch target.
- q_should_branch  out  1  branch taken (pulse with ALU done).
- i_new_data_uart1  in  1  UART byte strobe.
- q_uart1_tx_data  out  8  latched UART byte.
- q_gpio1  out  8  latched GPIO byte.

## Operation
- Opcodes (instr[15:11]): 00 MOV Rd=Ra; 01 MOVI Rd=imm8; 02 ADD Rd+Ra; 03 ADDI Rd+imm8; 04 SUB Rd−Ra; 05 SUBI Rd−imm8; 06 AND; 07 OR; 08 XOR.
- More opcodes: 09 LSL Rd<<simm5[3:0]; 0A LSR (logical); 0B CMP Rd,Ra (flags only); 0C Jcc imm8; 0D LW; 0E SW; 0F UART; 10 GPIO.
- All other opcodes, including 1F, decode as NOP.
- q_reg_we is 1 for ops 00–0A and 0D; 0 otherwise.
- Arithmetic is 16-bit modulo 2^16 and carries are discarded.
- LW/SW address: q_result = Ra + sign-extended simm5.
- CMP updates flags Z = (Rd==Ra) and N = (signed Rd < signed Ra). Flags are held until the next CMP; no other op touches them.
- Jcc: condition = seld. The codes are 0 EQ, 1 NE, 2 GT, 3 LT, 4 GE, 5 LE (all signed, from flags), 6 always, 7 never.
  - q_result = imm8 for Jcc.
  - q_should_branch = condition true.
- UART/GPIO: q_result = {8'h00, Rd[7:0]}.
- IO latch:
  - i_new_data_uart1 high → q_uart1_tx_data ← q_result[7:0].
  - GPIO completion → q_gpio1 ← q_result[7:0].

## Timing
- Decoder:
  - i_ce_dec & i_en at cycle n → all q_ fields registered and valid from n+1, held until the next accepted instruction.
  - At n+1 exactly one of q_ce_dec (non-NOP) or q_fetch (NOP) pulses for one cycle.
- ALU:
  - i_ce_alu at cycle m → q_result, flags and q_should_branch update at m+1.
  - Also at m+1, q_ce_ram (if i_dec_req_ram) or q_ce_reg (otherwise) pulses for one cycle.
  - q_result holds until the next i_ce_alu; q_should_branch is 1 only in the done cycle.
- IO: the UART latch updates at the edge after the strobe. The GPIO latch updates in the ALU done cycle + 1.
- Simultaneous i_ce_dec and i_ce_alu: both stages act independently. The ALU uses the q_op value current at its i_ce_alu edge.
- Reset (async, also mid-operation): all outputs, flags and latches go to 0; pending pulses are cancelled.

## Configuration
- PRCO_GPIO_EN defined: opcode 10 is GPIO and q_gpio1 latches as above.
- PRCO_GPIO_EN undefined: opcode 10 decodes as NOP (q_fetch) and q_gpio1 is constant 0.

## Structure
- `prco_pkg` holds the opcode localparams, condition codes, field bit positions and the 16/6/3-bit width constants.
- Natural sub-module: `prco_exec_alu` (ALU, flags, branch resolution). Decoder and IO latch stay in the top.

## Test plan
- Reset mid-run: after nonzero state, assert i_reset → every output and both flags read 0 immediately.
- ALU write-back: instr 0x1B05 (ADDI R3,#5) with i_datb=0xFFFE → q_ce_dec at n+1, q_reg_we=1; then i_ce_alu → q_result=0x0003 and q_ce_reg pulses one cycle.
- Signed branch: CMP with Rd=0xFFFF, Ra=0x0001 → N=1, Z=0. Then Jcc cond=3 imm8=0x2A → q_should_branch=1 and q_result=0x002A. Cond=2 → q_should_branch=0.
- Memory op: LW with Ra=0x0010, simm5=0x1F → q_result=0x000F and q_ce_ram pulses (not q_ce_reg). SW → q_req_ram_we=1.
- NOP: instr 0xF800 → q_fetch pulses and q_ce_dec stays 0. Same with i_en=0: no pulse at all.
- UART/GPIO: UART with Rd=0x12AB plus i_new_data_uart1 → q_uart1_tx_data=0xAB. GPIO with Rd=0x0055 → q_gpio1=0x55, or 0 with PRCO_GPIO_EN undefined.

Source files
------------

// File: rtl/prco_pkg.sv
// PRCO execute-side shared definitions: widths, opcodes, condition codes, field positions.
package prco_pkg;

    localparam int DW   = 16;
    localparam int OPW  = 6;
    localparam int SELW = 3;

    // Instruction field bit positions
    localparam int OP_HI    = 15;
    localparam int OP_LO    = 11;
    localparam int SELD_HI  = 10;
    localparam int SELD_LO  = 8;
    localparam int SELA_HI  = 7;
    localparam int SELA_LO  = 5;
    localparam int SELB_HI  = 4;
    localparam int SELB_LO  = 2;
    localparam int IMM8_HI  = 7;
    localparam int SIMM5_HI = 4;

    // Opcodes as seen on q_op
    localparam logic [OPW-1:0] OP_MOV  = 6'h00;
    localparam logic [OPW-1:0] OP_MOVI = 6'h01;
    localparam logic [OPW-1:0] OP_ADD  = 6'h02;
    localparam logic [OPW-1:0] OP_ADDI = 6'h03;
    localparam logic [OPW-1:0] OP_SUB  = 6'h04;
    localparam logic [OPW-1:0] OP_SUBI = 6'h05;
    localparam logic [OPW-1:0] OP_AND  = 6'h06;
    localparam logic [OPW-1:0] OP_OR   = 6'h07;
    localparam logic [OPW-1:0] OP_XOR  = 6'h08;
    localparam logic [OPW-1:0] OP_LSL  = 6'h09;
    localparam logic [OPW-1:0] OP_LSR  = 6'h0A;
    localparam logic [OPW-1:0] OP_CMP  = 6'h0B;
    localparam logic [OPW-1:0] OP_JCC  = 6'h0C;
    localparam logic [OPW-1:0] OP_LW   = 6'h0D;
    localparam logic [OPW-1:0] OP_SW   = 6'h0E;
    localparam logic [OPW-1:0] OP_UART = 6'h0F;
    localparam logic [OPW-1:0] OP_GPIO = 6'h10;

    // Jcc condition codes (carried in the Rd field)
    localparam logic [SELW-1:0] CC_EQ  = 3'd0;
    localparam logic [SELW-1:0] CC_NE  = 3'd1;
    localparam logic [SELW-1:0] CC_GT  = 3'd2;
    localparam logic [SELW-1:0] CC_LT  = 3'd3;
    localparam logic [SELW-1:0] CC_GE  = 3'd4;
    localparam logic [SELW-1:0] CC_LE  = 3'd5;
    localparam logic [SELW-1:0] CC_AL  = 3'd6;
    localparam logic [SELW-1:0] CC_NV  = 3'd7;

endpackage

// File: rtl/prco_exec_alu.sv
// PRCO single-cycle ALU: result register, Z/N compare flags, branch resolution.
// The GPIO-done output exists only when PRCO_GPIO_EN is defined.
module prco_exec_alu
    import prco_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_ce,
    input  logic            i_req_ram,
    input  logic [OPW-1:0]  i_op,
    input  logic [SELW-1:0] i_cond,
    input  logic [DW-1:0]   i_imm8,
    input  logic [4:0]      i_simm5,
    input  logic [DW-1:0]   i_data,
    input  logic [DW-1:0]   i_datb,
    output logic [DW-1:0]   o_result,
    output logic            o_branch,
    output logic            o_ce_ram,
    output logic            o_ce_reg,
`ifdef PRCO_GPIO_EN
    output logic            o_gpio_done,
`endif
    output logic            o_flag_z,
    output logic            o_flag_n
);

    logic [DW-1:0] r_result;
    logic          r_branch, r_ce_ram, r_ce_reg, r_flag_z, r_flag_n;
    logic [DW-1:0] w_res;
    logic          w_take, w_cmp, w_gpio;
    logic [DW-1:0] w_sext5;

    assign w_sext5 = {{(DW-5){i_simm5[4]}}, i_simm5};

    // Result mux and branch condition from the currently held flags
    always_comb begin
        w_res  = '0;
        w_take = 1'b0;
        w_cmp  = 1'b0;
        w_gpio = 1'b0;
        case (i_op)
            OP_MOV:  w_res = i_data;
            OP_MOVI: w_res = i_imm8;
            OP_ADD:  w_res = i_datb + i_data;
            OP_ADDI: w_res = i_datb + i_imm8;
            OP_SUB:  w_res = i_datb - i_data;
            OP_SUBI: w_res = i_datb - i_imm8;
            OP_AND:  w_res = i_datb & i_data;
            OP_OR:   w_res = i_datb | i_data;
            OP_XOR:  w_res = i_datb ^ i_data;
            OP_LSL:  w_res = i_datb << i_simm5[3:0];
            OP_LSR:  w_res = i_datb >> i_simm5[3:0];
            OP_CMP:  w_cmp = 1'b1;
            OP_JCC: begin
                w_res = i_imm8;
                case (i_cond)
                    CC_EQ:   w_take = r_flag_z;
                    CC_NE:   w_take = ~r_flag_z;
                    CC_GT:   w_take = ~r_flag_z & ~r_flag_n;
                    CC_LT:   w_take = r_flag_n;
                    CC_GE:   w_take = ~r_flag_n;
                    CC_LE:   w_take = r_flag_n | r_flag_z;
                    CC_AL:   w_take = 1'b1;
                    default: w_take = 1'b0;
                endcase
            end
            OP_LW, OP_SW: w_res = i_data + w_sext5;
            OP_UART: w_res = {8'h00, i_datb[7:0]};
`ifdef PRCO_GPIO_EN
            OP_GPIO: begin
                w_res  = {8'h00, i_datb[7:0]};
                w_gpio = 1'b1;
            end
`endif
            default: w_res = '0;
        endcase
    end

`ifdef PRCO_GPIO_EN
    logic r_gpio_done;
    assign o_gpio_done = r_gpio_done;

    // Remember that the completing op was GPIO, immune to later q_op changes
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)   r_gpio_done <= 1'b0;
        else           r_gpio_done <= i_ce & w_gpio;
    end
`endif

    // Result/flag registers and one-cycle completion pulses
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_result <= '0;
            r_branch <= 1'b0;
            r_ce_ram <= 1'b0;
            r_ce_reg <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
        end else begin
            r_branch <= 1'b0;
            r_ce_ram <= 1'b0;
            r_ce_reg <= 1'b0;
            if (i_ce) begin
                r_result <= w_res;
                r_branch <= w_take;
                r_ce_ram <= i_req_ram;
                r_ce_reg <= ~i_req_ram;
                if (w_cmp) begin
                    r_flag_z <= (i_datb == i_data);
                    r_flag_n <= ($signed(i_datb) < $signed(i_data));
                end
            end
        end
    end

    assign o_result = r_result;
    assign o_branch = r_branch;
    assign o_ce_ram = r_ce_ram;
    assign o_ce_reg = r_ce_reg;
    assign o_flag_z = r_flag_z;
    assign o_flag_n = r_flag_n;

endmodule

// File: rtl/prco_exu.sv
// PRCO execute unit: registered decoder, ALU instance, UART/GPIO output latches.
// Build option PRCO_GPIO_EN enables the GPIO opcode and the q_gpio1 latch.
module prco_exu
    import prco_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_en,
    input  logic            i_ce_dec,
    input  logic [DW-1:0]   i_instr,
    output logic            q_ce_dec,
    output logic            q_fetch,
    output logic [OPW-1:0]  q_op,
    output logic [SELW-1:0] q_seld,
    output logic [SELW-1:0] q_sela,
    output logic [SELW-1:0] q_selb,
    output logic            q_third_sel,
    output logic [DW-1:0]   q_imm8,
    output logic [4:0]      q_simm5,
    output logic            q_reg_we,
    output logic            q_req_ram,
    output logic            q_req_ram_we,
    output logic            q_new_uart1_data,
    input  logic            i_ce_alu,
    input  logic            i_dec_req_ram,
    input  logic [DW-1:0]   i_data,
    input  logic [DW-1:0]   i_datb,
    output logic            q_ce_ram,
    output logic            q_ce_reg,
    output logic [DW-1:0]   q_result,
    output logic            q_should_branch,
    input  logic            i_new_data_uart1,
    output logic [7:0]      q_uart1_tx_data,
    output logic [7:0]      q_gpio1
);

    logic [OPW-1:0] w_op;
    logic           w_valid, w_reg_we, w_third, w_req_ram, w_ram_we, w_uart;
    logic           w_flag_z, w_flag_n;
    logic [7:0]     r_uart1;

    assign w_op = {1'b0, i_instr[OP_HI:OP_LO]};

    // Per-opcode control bits for the incoming instruction
    always_comb begin
        w_valid   = 1'b1;
        w_reg_we  = 1'b0;
        w_third   = 1'b0;
        w_req_ram = 1'b0;
        w_ram_we  = 1'b0;
        w_uart    = 1'b0;
        case (w_op)
            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                w_reg_we = 1'b1;
                w_third  = i_instr[0];
            end
            OP_MOVI, OP_ADDI, OP_SUBI, OP_LSL, OP_LSR: w_reg_we = 1'b1;
            OP_CMP, OP_JCC: ;
            OP_LW: begin
                w_reg_we  = 1'b1;
                w_req_ram = 1'b1;
            end
            OP_SW: begin
                w_req_ram = 1'b1;
                w_ram_we  = 1'b1;
            end
            OP_UART: w_uart = 1'b1;
`ifdef PRCO_GPIO_EN
            OP_GPIO: ;
`endif
            default: w_valid = 1'b0;
        endcase
    end

    // Decoder register: capture fields on accepted instruction, pulse done/fetch once
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            q_ce_dec         <= 1'b0;
            q_fetch          <= 1'b0;
            q_op             <= '0;
            q_seld           <= '0;
            q_sela           <= '0;
            q_selb           <= '0;
            q_third_sel      <= 1'b0;
            q_imm8           <= '0;
            q_simm5          <= '0;
            q_reg_we         <= 1'b0;
            q_req_ram        <= 1'b0;
            q_req_ram_we     <= 1'b0;
            q_new_uart1_data <= 1'b0;
        end else begin
            q_ce_dec <= 1'b0;
            q_fetch  <= 1'b0;
            if (i_en && i_ce_dec) begin
                q_ce_dec         <= w_valid;
                q_fetch          <= ~w_valid;
                q_op             <= w_op;
                q_seld           <= i_instr[SELD_HI:SELD_LO];
                q_sela           <= i_instr[SELA_HI:SELA_LO];
                q_selb           <= i_instr[SELB_HI:SELB_LO];
                q_third_sel      <= w_third;
                q_imm8           <= {8'h00, i_instr[IMM8_HI:0]};
                q_simm5          <= i_instr[SIMM5_HI:0];
                q_reg_we         <= w_reg_we;
                q_req_ram        <= w_req_ram;
                q_req_ram_we     <= w_ram_we;
                q_new_uart1_data <= w_uart;
            end
        end
    end

`ifdef PRCO_GPIO_EN
    logic       w_gpio_done;
    logic [7:0] r_gpio1;
`endif

    prco_exec_alu u_alu (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_ce        (i_ce_alu),
        .i_req_ram   (i_dec_req_ram),
        .i_op        (q_op),
        .i_cond      (q_seld),
        .i_imm8      (q_imm8),
        .i_simm5     (q_simm5),
        .i_data      (i_data),
        .i_datb      (i_datb),
        .o_result    (q_result),
        .o_branch    (q_should_branch),
        .o_ce_ram    (q_ce_ram),
        .o_ce_reg    (q_ce_reg),
`ifdef PRCO_GPIO_EN
        .o_gpio_done (w_gpio_done),
`endif
        .o_flag_z    (w_flag_z),
        .o_flag_n    (w_flag_n)
    );

    // UART byte latch: grab the current result low byte on strobe
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)               r_uart1 <= '0;
        else if (i_new_data_uart1) r_uart1 <= q_result[7:0];
    end
    assign q_uart1_tx_data = r_uart1;

`ifdef PRCO_GPIO_EN
    // GPIO byte latch: load at the end of a GPIO op's done cycle
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)          r_gpio1 <= '0;
        else if (w_gpio_done) r_gpio1 <= q_result[7:0];
    end
    assign q_gpio1 = r_gpio1;
`else
    assign q_gpio1 = '0;
`endif

endmodule

// File: tb/tb_prco_exu.sv
// Directed self-checking bench for prco_exu (honours PRCO_GPIO_EN when defined).
module tb_prco_exu;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_en, i_ce_dec, i_ce_alu, i_dec_req_ram, i_new_data_uart1;
    logic [15:0] i_instr, i_data, i_datb;
    logic        q_ce_dec, q_fetch, q_third_sel, q_reg_we, q_req_ram, q_req_ram_we;
    logic        q_new_uart1_data, q_ce_ram, q_ce_reg, q_should_branch;
    logic [5:0]  q_op;
    logic [2:0]  q_seld, q_sela, q_selb;
    logic [15:0] q_imm8, q_result;
    logic [4:0]  q_simm5;
    logic [7:0]  q_uart1_tx_data, q_gpio1;

    int n_chk = 0;
    int n_err = 0;

    prco_exu dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en), .i_ce_dec(i_ce_dec),
        .i_instr(i_instr), .q_ce_dec(q_ce_dec), .q_fetch(q_fetch), .q_op(q_op),
        .q_seld(q_seld), .q_sela(q_sela), .q_selb(q_selb), .q_third_sel(q_third_sel),
        .q_imm8(q_imm8), .q_simm5(q_simm5), .q_reg_we(q_reg_we), .q_req_ram(q_req_ram),
        .q_req_ram_we(q_req_ram_we), .q_new_uart1_data(q_new_uart1_data),
        .i_ce_alu(i_ce_alu), .i_dec_req_ram(i_dec_req_ram), .i_data(i_data),
        .i_datb(i_datb), .q_ce_ram(q_ce_ram), .q_ce_reg(q_ce_reg), .q_result(q_result),
        .q_should_branch(q_should_branch), .i_new_data_uart1(i_new_data_uart1),
        .q_uart1_tx_data(q_uart1_tx_data), .q_gpio1(q_gpio1)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic dec(input logic [15:0] ins);
        i_instr  = ins;
        i_ce_dec = 1'b1;
        step();
        i_ce_dec = 1'b0;
    endtask

    task automatic alu(input logic [15:0] rd, input logic [15:0] ra, input logic rr);
        i_datb        = rd;
        i_data        = ra;
        i_dec_req_ram = rr;
        i_ce_alu      = 1'b1;
        step();
        i_ce_alu      = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1; i_en = 1'b1; i_ce_dec = 1'b0; i_ce_alu = 1'b0;
        i_dec_req_ram = 1'b0; i_new_data_uart1 = 1'b0;
        i_instr = '0; i_data = '0; i_datb = '0;
        step(); step();
        chk("rst_outs", {q_ce_dec, q_fetch, q_op, q_reg_we, q_ce_reg, q_ce_ram, q_should_branch}, '0);
        chk("rst_result", {q_result, q_uart1_tx_data, q_gpio1}, '0);
        i_reset = 1'b0;
        step();

        // ADDI R3,#5 with Rd=0xFFFE wraps to 3
        dec(16'h1B05);
        chk("addi_pulse", {q_ce_dec, q_fetch}, 2'b10);
        chk("addi_fields", {q_op, q_seld, q_imm8, q_reg_we, q_third_sel}, {6'h03, 3'd3, 16'h0005, 1'b1, 1'b0});
        alu(16'hFFFE, 16'h1234, 1'b0);
        chk("addi_res", q_result, 16'h0003);
        chk("addi_done", {q_ce_reg, q_ce_ram, q_ce_dec}, 3'b100);
        step();
        chk("addi_done_1cyc", {q_ce_reg, q_ce_ram}, 2'b00);
        chk("addi_hold", q_result, 16'h0003);

        // ADD 3-register form
        dec(16'h1141);
        chk("add_fields", {q_op, q_seld, q_sela, q_third_sel}, {6'h02, 3'd1, 3'd2, 1'b1});
        alu(16'h8000, 16'h8001, 1'b0);
        chk("add_res", q_result, 16'h0001);

        // SUB underflow and LSL
        dec(16'h2140);
        alu(16'h0005, 16'h0007, 1'b0);
        chk("sub_res", q_result, 16'hFFFE);
        dec(16'h4804);
        alu(16'h0123, 16'h0000, 1'b0);
        chk("lsl_res", q_result, 16'h1230);

        // CMP -1 vs 1: signed less-than
        dec(16'h5940);
        chk("cmp_we", q_reg_we, 1'b0);
        alu(16'hFFFF, 16'h0001, 1'b0);
        chk("cmp_flags", {dut.w_flag_z, dut.w_flag_n}, 2'b01);

        dec(16'h632A);
        alu(16'h0000, 16'h0000, 1'b0);
        chk("jlt_taken", {q_should_branch, q_result}, {1'b1, 16'h002A});
        step();
        chk("jlt_pulse", q_should_branch, 1'b0);
        dec(16'h622A);
        alu(16'h0000, 16'h0000, 1'b0);
        chk("jgt_not", {q_should_branch, q_ce_reg}, 2'b01);
        dec(16'h652A);
        alu(16'h0000, 16'h0000, 1'b0);
        chk("jle_taken", q_should_branch, 1'b1);

        // LW: Ra + sext(0x1F) = 0x10 - 1
        dec(16'h681F);
        chk("lw_fields", {q_req_ram, q_req_ram_we, q_reg_we}, 3'b101);
        alu(16'h0000, 16'h0010, 1'b1);
        chk("lw_res", q_result, 16'h000F);
        chk("lw_done", {q_ce_ram, q_ce_reg}, 2'b10);
        dec(16'h7000);
        chk("sw_fields", {q_req_ram, q_req_ram_we, q_reg_we}, 3'b110);

        // NOP, then disabled decoder
        dec(16'hF800);
        chk("nop_pulse", {q_ce_dec, q_fetch, q_op}, {1'b0, 1'b1, 6'h1F});
        step();
        chk("nop_1cyc", {q_ce_dec, q_fetch}, 2'b00);
        i_en = 1'b0;
        dec(16'h1B05);
        chk("en0_none", {q_ce_dec, q_fetch, q_op}, {1'b0, 1'b0, 6'h1F});
        i_en = 1'b1;

        // UART byte
        dec(16'h7800);
        chk("uart_dec", {q_ce_dec, q_new_uart1_data}, 2'b11);
        alu(16'h12AB, 16'h0000, 1'b0);
        chk("uart_res", q_result, 16'h00AB);
        i_new_data_uart1 = 1'b1;
        step();
        i_new_data_uart1 = 1'b0;
        chk("uart_latch", q_uart1_tx_data, 8'hAB);

        // GPIO byte
        dec(16'h8000);
`ifdef PRCO_GPIO_EN
        chk("gpio_dec", {q_ce_dec, q_fetch}, 2'b10);
        alu(16'h0055, 16'h0000, 1'b0);
        chk("gpio_early", q_gpio1, 8'h00);
        step();
        chk("gpio_latch", q_gpio1, 8'h55);
`else
        chk("gpio_dec", {q_ce_dec, q_fetch}, 2'b01);
        alu(16'h0055, 16'h0000, 1'b0);
        step();
        chk("gpio_latch", q_gpio1, 8'h00);
`endif

        // Async reset mid-operation, between edges
        dec(16'h1B05);
        i_ce_alu = 1'b1; i_datb = 16'h0010;
        #2;
        i_reset = 1'b1;
        #1;
        chk("mid_rst_dec", {q_ce_dec, q_op, q_seld, q_imm8, q_reg_we}, '0);
        chk("mid_rst_alu", {q_result, q_uart1_tx_data, q_gpio1, q_ce_reg, q_should_branch}, '0);
        chk("mid_rst_flags", {dut.w_flag_z, dut.w_flag_n}, 2'b00);
        i_ce_alu = 1'b0;
        step();
        i_reset = 1'b0;
        step();
        chk("post_rst", {q_ce_reg, q_ce_dec, q_result}, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
